// File: rtl/jk_pkg_311.sv
// rtl/jk_pkg_311.sv - shared state encoding, JK excitation table and modulo step for jk_count_ctrl_311
package jk_pkg_311;

  typedef enum logic [1:0] {
    S_CLR  = 2'd0,
    S_IDLE = 2'd1,
    S_RUN  = 2'd2
  } state_t;

  // Indexed by {current_bit, target_bit}; bit 3 (1->1) and bit 0 (0->0) both hold, never toggle.
  localparam logic [3:0] EXC_J_TBL = 4'b0010;
  localparam logic [3:0] EXC_K_TBL = 4'b0100;

  function automatic int next_mod(input int cnt, input logic up, input int modulus);
    if (up) begin
      return (cnt >= modulus - 1) ? 0 : cnt + 1;
    end
    return (cnt == 0 || cnt >= modulus) ? modulus - 1 : cnt - 1;
  endfunction

endpackage

// File: rtl/jk_excite_311.sv
// rtl/jk_excite_311.sv - per-bit J/K excitation from current to target count
module jk_excite_311
  import jk_pkg_311::*;
#(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH-1:0] cur_i,
  input  logic [WIDTH-1:0] tgt_i,
  output logic [WIDTH-1:0] j_o,
  output logic [WIDTH-1:0] k_o
);

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    assign j_o[i] = EXC_J_TBL[{cur_i[i], tgt_i[i]}];
    assign k_o[i] = EXC_K_TBL[{cur_i[i], tgt_i[i]}];
  end

endmodule

// File: rtl/jk_count_ctrl_311.sv
// rtl/jk_count_ctrl_311.sv - mod-MOD up/down sequencer for a negedge JK flip-flop bank
// Optional Q/shadow mismatch checker enabled by JKCTL_MISMATCH_CHECK_EN.
module jk_count_ctrl_311
  import jk_pkg_311::*;
#(
  parameter int WIDTH = 4,
  parameter int MOD   = 10
) (
  input  logic             clk_311,
  input  logic             reset_n,
  input  logic             start_311,
  input  logic             stop_311,
  input  logic             up_dn_311,
  input  logic             load_311,
  input  logic [WIDTH-1:0] load_val_311,
  input  logic [WIDTH-1:0] q_in_311,
  output logic [WIDTH-1:0] j_311,
  output logic [WIDTH-1:0] k_311,
  output logic             bank_clr_311,
  output logic [WIDTH-1:0] cnt_311,
  output logic             busy_311,
  output logic             tc_311,
  output logic             err_311
);

  state_t           state_q, state_d;
  logic [WIDTH-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] j_q, j_d, k_q, k_d;
  logic             clr_q, clr_d;
  logic             busy_q, busy_d;
  logic             tc_q, tc_d;

  logic [WIDTH-1:0] step_val, load_tgt, tgt, j_x, k_x;
  logic             wrap;

  assign step_val = WIDTH'(next_mod(int'(cnt_q), up_dn_311, MOD));
  assign load_tgt = (int'(load_val_311) >= MOD) ? '0 : load_val_311;
  assign wrap     = up_dn_311 ? (cnt_q == WIDTH'(MOD - 1)) : (cnt_q == '0);

  jk_excite_311 #(.WIDTH(WIDTH)) u_excite (
    .cur_i(cnt_q),
    .tgt_i(tgt),
    .j_o  (j_x),
    .k_o  (k_x)
  );

  // Holding (tgt == cnt_q) yields J=K=0, which is what S_CLR and stop both need.
  always_comb begin
    state_d = state_q;
    tgt     = cnt_q;
    tc_d    = 1'b0;
    clr_d   = 1'b0;
    case (state_q)
      S_CLR: state_d = S_IDLE;
      S_IDLE: begin
        if (load_311) begin
          tgt = load_tgt;
        end else if (start_311 && !stop_311) begin
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        if (stop_311) begin
          state_d = S_IDLE;
        end
        if (load_311) begin
          tgt = load_tgt;
        end else if (!stop_311) begin
          tgt  = step_val;
          tc_d = wrap;
        end
      end
      default: state_d = S_IDLE;
    endcase
    cnt_d  = tgt;
    j_d    = j_x;
    k_d    = k_x;
    busy_d = (state_d == S_RUN);
  end

  always_ff @(posedge clk_311 or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_CLR;
      cnt_q   <= '0;
      j_q     <= '0;
      k_q     <= '0;
      clr_q   <= 1'b1;
      busy_q  <= 1'b0;
      tc_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      j_q     <= j_d;
      k_q     <= k_d;
      clr_q   <= clr_d;
      busy_q  <= busy_d;
      tc_q    <= tc_d;
    end
  end

`ifdef JKCTL_MISMATCH_CHECK_EN
  logic err_q;

  // q_in at this edge reflects the negedge that applied the cnt_q now being replaced.
  always_ff @(posedge clk_311 or negedge reset_n) begin
    if (!reset_n) begin
      err_q <= 1'b0;
    end else if (state_q != S_CLR && q_in_311 != cnt_q) begin
      err_q <= 1'b1;
    end
  end

  assign err_311 = err_q;
`else
  logic unused_q_in;
  assign unused_q_in = ^q_in_311;
  assign err_311     = 1'b0;
`endif

  assign j_311        = j_q;
  assign k_311        = k_q;
  assign bank_clr_311 = clr_q;
  assign cnt_311      = cnt_q;
  assign busy_311     = busy_q;
  assign tc_311       = tc_q;

endmodule
